// File: rtl/score_digit_renderer.sv
// Per-player BCD score counter rendered straight from the VGA beam position, with win blink.
// Optional: define SCORE_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_digit_renderer #(
  parameter int unsigned              DIGITS       = 2,
  parameter int unsigned              SCALE_LOG2   = 3,
  parameter int unsigned              X0           = 16,
  parameter int unsigned              Y0           = 16,
  parameter logic [4*DIGITS-1:0]      WIN_SCORE    = 8'h11,
  parameter int unsigned              BLINK_FRAMES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  clr,
  input  logic                  frame_tick,
  input  logic                  video_on,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  output logic                  pixel,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic                  win
);

  localparam int unsigned W          = 4 * DIGITS;
  localparam logic [9:0]  X0_L       = 10'(X0);
  localparam logic [9:0]  Y0_L       = 10'(Y0);
  localparam logic [9:0]  FX_LIM     = 10'(4 * DIGITS);
  localparam logic [9:0]  FY_LIM     = 10'd5;
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [1:0]  TOP_DIGIT  = 2'(DIGITS - 1);

  logic [W-1:0] score_q, score_d, score_inc;
  logic         win_q, win_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         phase_q, phase_d;
  logic         pixel_q, pixel_d;
  logic         all_nine, carry;

  logic [9:0]   dx, dy, fx, fy;
  logic         region;
  logic [1:0]   cell_k, col_c, dig_idx;
  logic [2:0]   row_r;
  logic [3:0]   nib, bit_idx;
  logic [14:0]  glyph;
  logic         blank;

  // Rows top to bottom, three bits each, leftmost column in the MSB of each row.
  function automatic logic [14:0] glyph_bits(input logic [3:0] d);
    unique case (d)
      4'd0:    glyph_bits = 15'b111_101_101_101_111;
      4'd1:    glyph_bits = 15'b010_110_010_010_010;
      4'd2:    glyph_bits = 15'b111_001_111_100_111;
      4'd3:    glyph_bits = 15'b111_001_111_001_111;
      4'd4:    glyph_bits = 15'b101_101_111_001_001;
      4'd5:    glyph_bits = 15'b111_100_111_001_111;
      4'd6:    glyph_bits = 15'b111_100_111_101_111;
      4'd7:    glyph_bits = 15'b111_001_010_010_010;
      4'd8:    glyph_bits = 15'b111_101_111_101_111;
      4'd9:    glyph_bits = 15'b111_101_111_001_111;
      default: glyph_bits = 15'b0;
    endcase
  endfunction

  // BCD increment with ripple carry, resolved within one cycle.
  always_comb begin
    all_nine  = 1'b1;
    carry     = 1'b1;
    score_inc = score_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (inc && !all_nine) begin
      score_d = score_inc;
    end
    win_d = (score_d == WIN_SCORE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!win_q) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (frame_tick) begin
      if (cnt_q == BLINK_LAST) begin
        cnt_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    dx      = pixel_x - X0_L;
    dy      = pixel_y - Y0_L;
    fx      = dx >> SCALE_LOG2;
    fy      = dy >> SCALE_LOG2;
    region  = (pixel_x >= X0_L) && (pixel_y >= Y0_L) && (fx < FX_LIM) && (fy < FY_LIM);
    cell_k  = fx[3:2];
    col_c   = fx[1:0];
    row_r   = fy[2:0];
    // Cell 0 is the leftmost on screen, which holds the most significant digit.
    dig_idx = TOP_DIGIT - cell_k;
    nib     = 4'd0;
    blank   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_idx == 2'(i)) nib = score_q[4*i +: 4];
    end
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    begin : lead_zero
      logic zero_run;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_run = zero_run && (score_q[4*i +: 4] == 4'd0);
        if (zero_run && (dig_idx == 2'(i))) blank = 1'b1;
      end
    end
`endif
    glyph   = glyph_bits(nib);
    bit_idx = 4'd14 - (4'(row_r) * 4'd3 + 4'(col_c));
    pixel_d = video_on && region && (col_c != 2'd3) && !blank && !phase_q &&
              (bit_idx < 4'd15) && glyph[bit_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
      win_q   <= 1'b0;
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
      pixel_q <= 1'b0;
    end else begin
      score_q <= score_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pixel_q <= pixel_d;
    end
  end

  assign pixel     = pixel_q;
  assign score_bcd = score_q;
  assign win       = win_q;

endmodule
